// File: rtl/mips16_pkg.sv
// Shared definitions for the mips16 core: opcode/funct constants, field slicers
// and the pipeline-register layouts.
package mips16_pkg;

    localparam logic [2:0] OP_RTYPE   = 3'b000;
    localparam logic [2:0] OP_ADDI    = 3'b001;

    localparam logic [3:0] FUNCT_ADD  = 4'b0001;
    localparam logic [3:0] FUNCT_SUB  = 4'b0010;
    localparam logic [3:0] FUNCT_AND  = 4'b0011;
    localparam logic [3:0] FUNCT_OR   = 4'b0100;
    localparam logic [3:0] FUNCT_SLT  = 4'b0101;
    localparam logic [3:0] FUNCT_SLL1 = 4'b0110;
    localparam logic [3:0] FUNCT_SRL1 = 4'b0111;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL1,
        ALU_SRL1
    } alu_op_e;

    typedef struct packed {
        logic [15:0] instr;
    } if_id_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  dest;
        alu_op_e     alu;
        logic [15:0] a;
        logic [15:0] b;
    } id_ex_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  dest;
        logic [15:0] data;
    } ex_mem_t;

    typedef ex_mem_t mem_wb_t;

    function automatic logic [2:0] f_op(input logic [15:0] instr);
        return instr[15:13];
    endfunction

    function automatic logic [2:0] f_rs(input logic [15:0] instr);
        return instr[12:10];
    endfunction

    function automatic logic [2:0] f_rt(input logic [15:0] instr);
        return instr[9:7];
    endfunction

    function automatic logic [2:0] f_rd(input logic [15:0] instr);
        return instr[6:4];
    endfunction

    function automatic logic [3:0] f_funct(input logic [15:0] instr);
        return instr[3:0];
    endfunction

    function automatic logic [15:0] f_imm_sext(input logic [15:0] instr);
        return {{9{instr[6]}}, instr[6:0]};
    endfunction

endpackage

// File: rtl/mips16_regfile.sv
// 8x16 register file, two read ports and one write port. r0 is hardwired to zero;
// a read of the register being written this cycle returns the new value.
module mips16_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  raddr_a,
    input  logic [2:0]  raddr_b,
    output logic [15:0] rdata_a,
    output logic [15:0] rdata_b,
    input  logic        we,
    input  logic [2:0]  waddr,
    input  logic [15:0] wdata
);

    logic [15:0] regs [8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != 3'd0) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a = regs[raddr_a];
        if (raddr_a == 3'd0) begin
            rdata_a = '0;
        end else if (we && waddr == raddr_a) begin
            rdata_a = wdata;
        end
    end

    always_comb begin
        rdata_b = regs[raddr_b];
        if (raddr_b == 3'd0) begin
            rdata_b = '0;
        end else if (we && waddr == raddr_b) begin
            rdata_b = wdata;
        end
    end

endmodule

// File: rtl/mips16_core.sv
// Five-stage 16-bit MIPS-style core with a streamed-in instruction memory.
// No forwarding or hazard detection; dout mirrors every non-r0 write-back.
module mips16_core
    import mips16_pkg::*;
#(
    parameter int IMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] din,
    input  logic        wen,
    input  logic        pc_reset,
    input  logic        rd_en,
    output logic [15:0] dout
);

    localparam int AW = $clog2(IMEM_DEPTH);

    logic [15:0]   imem [IMEM_DEPTH];
    logic [AW-1:0] pc;
    logic [AW-1:0] ptr;

    if_id_t  if_id;
    id_ex_t  id_ex;
    ex_mem_t ex_mem;
    mem_wb_t mem_wb;

    logic        advance;
    logic        wb_we;
    logic [15:0] fetch_word;
    logic [15:0] rdata_a;
    logic [15:0] rdata_b;
    id_ex_t      id_next;
    logic [15:0] alu_res;

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return (a == AW'(IMEM_DEPTH - 1)) ? '0 : a + AW'(1);
    endfunction

    assign advance = rd_en && !wen;
    // A flush on this edge wins over the instruction sitting in MEM/WB.
    assign wb_we   = advance && !pc_reset && mem_wb.we && (mem_wb.dest != 3'd0);

    // Words at or beyond the load pointer have never been written: run them as NOPs.
    assign fetch_word = (pc < ptr) ? imem[pc] : 16'h0000;

    always_ff @(posedge clk) begin
        if (wen) begin
            imem[ptr] <= din;
        end
    end

    mips16_regfile u_regfile (
        .clk     (clk),
        .reset   (reset),
        .raddr_a (f_rs(if_id.instr)),
        .raddr_b (f_rt(if_id.instr)),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .we      (wb_we),
        .waddr   (mem_wb.dest),
        .wdata   (mem_wb.data)
    );

    always_comb begin
        id_next   = '0;
        id_next.a = rdata_a;
        case (f_op(if_id.instr))
            OP_RTYPE: begin
                id_next.b    = rdata_b;
                id_next.dest = f_rd(if_id.instr);
                id_next.we   = 1'b1;
                case (f_funct(if_id.instr))
                    FUNCT_ADD:  id_next.alu = ALU_ADD;
                    FUNCT_SUB:  id_next.alu = ALU_SUB;
                    FUNCT_AND:  id_next.alu = ALU_AND;
                    FUNCT_OR:   id_next.alu = ALU_OR;
                    FUNCT_SLT:  id_next.alu = ALU_SLT;
                    FUNCT_SLL1: id_next.alu = ALU_SLL1;
                    FUNCT_SRL1: id_next.alu = ALU_SRL1;
                    default:    id_next.we  = 1'b0;
                endcase
            end
            OP_ADDI: begin
                id_next.b    = f_imm_sext(if_id.instr);
                id_next.dest = f_rt(if_id.instr);
                id_next.we   = 1'b1;
                id_next.alu  = ALU_ADD;
            end
            default: ;
        endcase
    end

    // Shift ops act on the rt operand only.
    always_comb begin
        alu_res = '0;
        case (id_ex.alu)
            ALU_ADD:  alu_res = id_ex.a + id_ex.b;
            ALU_SUB:  alu_res = id_ex.a - id_ex.b;
            ALU_AND:  alu_res = id_ex.a & id_ex.b;
            ALU_OR:   alu_res = id_ex.a | id_ex.b;
            ALU_SLT:  alu_res = {15'd0, ($signed(id_ex.a) < $signed(id_ex.b))};
            ALU_SLL1: alu_res = {id_ex.b[14:0], 1'b0};
            ALU_SRL1: alu_res = {1'b0, id_ex.b[15:1]};
            default:  alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= '0;
            ptr    <= '0;
            if_id  <= '0;
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
            dout   <= '0;
        end else begin
            if (wen) begin
                ptr <= next_addr(ptr);
            end
            if (pc_reset) begin
                pc     <= '0;
                if_id  <= '0;
                id_ex  <= '0;
                ex_mem <= '0;
                mem_wb <= '0;
            end else if (advance) begin
                pc           <= next_addr(pc);
                if_id.instr  <= fetch_word;
                id_ex        <= id_next;
                ex_mem.we    <= id_ex.we;
                ex_mem.dest  <= id_ex.dest;
                ex_mem.data  <= alu_res;
                mem_wb       <= ex_mem;
                if (wb_we) begin
                    dout <= mem_wb.data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips16_core.sv
// Directed bench for mips16_core: loads programs, runs them and scoreboards every
// cycle of dout against expected write-back values queued at load time.
module tb_mips16_core;

  logic        clk;
  logic        reset;
  logic [15:0] din;
  logic        wen;
  logic        pc_reset;
  logic        rd_en;
  logic [15:0] dout;

  int checks;
  int failures;
  int run_edges;
  logic [15:0] exp_dout;
  // bit 16 = instruction writes back, bits 15:0 = value; popped on its WB edge
  logic [16:0] exp_q[$];

  mips16_core dut (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .wen      (wen),
    .pc_reset (pc_reset),
    .rd_en    (rd_en),
    .dout     (dout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: dout=%h expected=%h", tag, got, want);
    end
  endtask

  // drivers
  task automatic load_word(input logic [15:0] w, input logic wr, input logic [15:0] val,
                           input logic with_pcr);
    din      = w;
    wen      = 1'b1;
    pc_reset = with_pcr;
    @(posedge clk);
    @(negedge clk);
    wen      = 1'b0;
    pc_reset = 1'b0;
    exp_q.push_back({wr, val});
    check($sformatf("load_hold_%h", w), dout, exp_dout);
  endtask

  task automatic push_hold(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(17'h0);
  endtask

  task automatic step(input logic stall);
    logic [16:0] e;
    rd_en = !stall;
    @(posedge clk);
    @(negedge clk);
    if (!stall) begin
      run_edges++;
      if (run_edges >= 5 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[16]) exp_dout = e[15:0];
      end
    end
    check($sformatf("%s@%0d", stall ? "stall" : "run", run_edges), dout, exp_dout);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    run_edges = 0;
    exp_dout  = 16'h0;
    reset     = 1'b0;
    din       = 16'h0;
    wen       = 1'b0;
    pc_reset  = 1'b0;
    rd_en     = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("reset_dout", dout, 16'h0000);

    // advance PC over empty memory so the later pc_reset has something to undo
    for (int i = 0; i < 3; i++) step(1'b0);
    rd_en = 1'b0;

    // program 1
    load_word(16'h2081, 1'b1, 16'd1, 1'b0);
    load_word(16'h2102, 1'b1, 16'd2, 1'b0);
    load_word(16'h2183, 1'b1, 16'd3, 1'b0);
    load_word(16'h2204, 1'b1, 16'd4, 1'b0);
    load_word(16'h2285, 1'b1, 16'd5, 1'b0);
    load_word(16'h2306, 1'b1, 16'd6, 1'b0);
    load_word(16'h2387, 1'b1, 16'd7, 1'b0);
    load_word(16'h0541, 1'b1, 16'd3, 1'b0);
    for (int i = 0; i < 3; i++) load_word(16'h0000, 1'b0, 16'h0, 1'b0);
    load_word(16'h1E12, 1'b1, 16'd4, 1'b0);
    for (int i = 0; i < 3; i++) load_word(16'h0000, 1'b0, 16'h0, 1'b0);
    load_word(16'h19A2, 1'b1, 16'd3, 1'b0);
    for (int i = 0; i < 3; i++) load_word(16'h0000, 1'b0, 16'h0, 1'b0);
    load_word(16'h0C61, 1'b1, 16'd3, 1'b0);
    for (int i = 0; i < 3; i++) load_word(16'h0000, 1'b0, 16'h0, 1'b0);
    load_word(16'h06D7, 1'b1, 16'd2, 1'b0);
    for (int i = 0; i < 3; i++) load_word(16'h0000, 1'b0, 16'h0, 1'b0);
    load_word(16'h3681, 1'b1, 16'd3, 1'b0);
    for (int i = 0; i < 3; i++) load_word(16'h0000, 1'b0, 16'h0, 1'b0);
    // last word loaded on the same edge as pc_reset: both must take effect
    load_word(16'h1E72, 1'b1, 16'd4, 1'b1);
    push_hold(8);
    run_edges = 0;
    for (int i = 0; i < 44; i++) begin
      if (i == 15) begin
        for (int s = 0; s < 5; s++) step(1'b1);
      end
      step(1'b0);
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL queue_drain_1: left=%0d expected=0", exp_q.size());
    end

    // asynchronous reset while running
    for (int i = 0; i < 2; i++) step(1'b0);
    #2 reset = 1'b0;
    #1 exp_dout = 16'h0;
    check("async_reset_dout", dout, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    rd_en = 1'b0;

    // program 2: reset regs, back-to-back hazard, write-through, remaining ALU ops
    load_word(16'h0541, 1'b1, 16'h0000, 1'b0);
    load_word(16'h2081, 1'b1, 16'h0001, 1'b0);
    load_word(16'h3081, 1'b1, 16'h0001, 1'b0);
    load_word(16'h2105, 1'b1, 16'h0005, 1'b0);
    for (int i = 0; i < 2; i++) load_word(16'h0000, 1'b0, 16'h0, 1'b0);
    load_word(16'h08B1, 1'b1, 16'h0006, 1'b0);
    for (int i = 0; i < 3; i++) load_word(16'h0000, 1'b0, 16'h0, 1'b0);
    load_word(16'h09C3, 1'b1, 16'h0004, 1'b0);
    load_word(16'h09D4, 1'b1, 16'h0007, 1'b0);
    load_word(16'h23FF, 1'b1, 16'hFFFF, 1'b0);
    load_word(16'h01E6, 1'b1, 16'h000C, 1'b0);
    for (int i = 0; i < 3; i++) load_word(16'h0000, 1'b0, 16'h0, 1'b0);
    load_word(16'h1D15, 1'b1, 16'h0001, 1'b0);
    load_word(16'h0BA5, 1'b1, 16'h0000, 1'b0);
    load_word(16'h03B7, 1'b1, 16'h7FFF, 1'b0);
    load_word(16'h0548, 1'b0, 16'h0, 1'b0);
    load_word(16'h4081, 1'b0, 16'h0, 1'b0);
    load_word(16'h1FD1, 1'b1, 16'hFFFE, 1'b0);
    load_word(16'h2005, 1'b0, 16'h0, 1'b0);
    push_hold(4);
    run_edges = 0;
    for (int i = 0; i < 32; i++) step(1'b0);
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL queue_drain_2: left=%0d expected=0", exp_q.size());
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
